// File: rtl/grey_pkg.sv
// Types and helpers shared by both ends of the grey counter link.
package grey_pkg;

    typedef enum logic [1:0] {WARM, HUNT, LOCKED} state_e;
    typedef enum logic [1:0] {IDLE, UP, DOWN, JUMP} step_e;

    localparam logic [1:0] SEL_STATUS = 2'd0;
    localparam logic [1:0] SEL_BCD_LO = 2'd1;
    localparam logic [1:0] SEL_BCD_HI = 2'd2;
    localparam logic [1:0] SEL_ERR    = 2'd3;

    localparam logic [1:0] WARM_LAST = 2'd2;
    localparam logic [3:0] BCD_MAX   = 4'd9;
    localparam int         GW        = 32;

    // Zero-extended high bits contribute nothing to the prefix XOR, so one
    // fixed-width routine serves any narrower Gray width.
    function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
        logic [GW-1:0] b;
        b[GW-1] = g[GW-1];
        for (int i = GW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/grey_rx_bcd_digit.sv
// One BCD digit of the up/down step counter; digits ripple via carry_i/carry_o.
module bcd_updown_digit
    import grey_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       inc_i,
    input  logic       dec_i,
    input  logic       carry_i,
    output logic       carry_o,
    output logic [3:0] digit_o
);

    logic [3:0] digit_q, digit_d;

    // carry_i enables this digit; carry_o is a carry when counting up and a borrow when counting down.
    always_comb begin
        digit_d = digit_q;
        carry_o = 1'b0;
        if (carry_i && inc_i) begin
            if (digit_q == BCD_MAX) begin
                digit_d = 4'd0;
                carry_o = 1'b1;
            end else begin
                digit_d = digit_q + 4'd1;
            end
        end else if (carry_i && dec_i) begin
            if (digit_q == 4'd0) begin
                digit_d = BCD_MAX;
                carry_o = 1'b1;
            end else begin
                digit_d = digit_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) digit_q <= 4'd0;
        else       digit_q <= digit_d;
    end

    assign digit_o = digit_q;

endmodule

// File: rtl/grey_rx.sv
// Gray-code link receiver: synchronise, decode, classify steps, lock, count in BCD.
module grey_rx
    import grey_pkg::*;
#(
    parameter int W      = 6,
    parameter int DIGITS = 4,
    parameter int LOCK_N = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_gray,
    input  logic [1:0]   i_sel,
    output logic [7:0]   o_out
);

    logic [W-1:0] s1_q, s2_q, prev_q, bin, diff;
    step_e        step;
    state_e       state_q, state_d;
    logic [1:0]   warm_q, warm_d;
    logic [3:0]   lock_q, lock_d;
    logic         bcd_inc, bcd_dec, jump_err, legal;
    logic [7:0]   err_cnt_q, out_q, out_d;
    logic         err_sticky_q, dir_q, locked;
    logic [DIGITS:0]     carry;
    logic [4*DIGITS-1:0] bcd;
    logic [5:0]   bin6;
    logic [7:0]   bcd_hi;
    logic         wrap_unused;

    assign bin  = W'(gray2bin(GW'(s2_q)));
    assign diff = bin - prev_q;

    always_comb begin
        if (diff == '0)           step = IDLE;
        else if (diff == W'(1))   step = UP;
        else if (diff == '1)      step = DOWN;
        else                      step = JUMP;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= WARM;
            warm_q  <= 2'd0;
            lock_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            lock_q  <= lock_d;
        end
    end

    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        lock_d  = lock_q;
        case (state_q)
            WARM: begin
                warm_d = warm_q + 2'd1;
                if (warm_q == WARM_LAST) state_d = HUNT;
            end
            HUNT: begin
                if (step == UP || step == DOWN) begin
                    lock_d = lock_q + 4'd1;
                    if (lock_q == 4'(LOCK_N - 1)) state_d = LOCKED;
                end else if (step == JUMP) begin
                    lock_d = 4'd0;
                end
            end
            LOCKED: begin
                if (step == JUMP) begin
                    state_d = HUNT;
                    lock_d  = 4'd0;
                end
            end
            default: state_d = WARM;
        endcase
    end

    // Warm-up only primes prev; steps are acted on from HUNT onward.
    always_comb begin
        bcd_inc  = 1'b0;
        bcd_dec  = 1'b0;
        jump_err = 1'b0;
        legal    = 1'b0;
        if (state_q != WARM) begin
            jump_err = (step == JUMP);
            legal    = (step == UP) || (step == DOWN);
        end
        if (state_q == LOCKED) begin
            bcd_inc = (step == UP);
            bcd_dec = (step == DOWN);
        end
    end

    assign carry[0] = bcd_inc | bcd_dec;
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_updown_digit u_digit (
            .clk_i   (i_clk),
            .rst_i   (i_rst),
            .inc_i   (bcd_inc),
            .dec_i   (bcd_dec),
            .carry_i (carry[k]),
            .carry_o (carry[k+1]),
            .digit_o (bcd[4*k +: 4])
        );
    end
    // Carry out of the top digit is dropped, giving the all-9/all-0 wrap.
    assign wrap_unused = carry[DIGITS];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_q         <= '0;
            s2_q         <= '0;
            prev_q       <= '0;
            err_cnt_q    <= 8'd0;
            err_sticky_q <= 1'b0;
            dir_q        <= 1'b0;
            out_q        <= 8'd0;
        end else begin
            s1_q   <= i_gray;
            s2_q   <= s1_q;
            prev_q <= bin;
            out_q  <= out_d;
            if (legal) dir_q <= (step == UP);
            if (jump_err) begin
                err_sticky_q <= 1'b1;
                if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    if (W >= 6) begin : g_bin_trunc
        assign bin6 = bin[5:0];
    end else begin : g_bin_ext
        assign bin6 = {{(6 - W){1'b0}}, bin};
    end

    if (DIGITS >= 4) begin : g_hi
        assign bcd_hi = bcd[15:8];
    end else begin : g_no_hi
        assign bcd_hi = 8'd0;
    end

    assign locked = (state_q == LOCKED);

    always_comb begin
        case (i_sel)
            SEL_STATUS: out_d = {locked, err_sticky_q, bin6};
            SEL_BCD_LO: out_d = bcd[7:0];
            SEL_BCD_HI: out_d = bcd_hi;
            SEL_ERR:    out_d = {dir_q, err_cnt_q[6:0]};
            default:    out_d = 8'd0;
        endcase
    end

    assign o_out = out_q;

endmodule
